dma_chan_arbiter: RTL and testbench
===================================

# dma_chan_arbiter

Parametrised round-robin channel arbiter for the DMA controller. It samples per-channel transfer requests, grants one channel at a time, and holds the grant until the datapath reports completion. The grant is presented both as a binary channel index and as a registered one-hot select vector. It is the registered, multi-channel, fairness-aware successor to the fixed combinational 4-to-16 decoder, and it sits between the channel register file and the transfer engine.

## Interface
- CH_NUM, 16, number of DMA channels; legal range 2..64, need not be a power of two.
- IDX_W, 4, width of the channel index; must satisfy 2**IDX_W >= CH_NUM.
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- en_i  input  1  arbitration enable; low blocks new grants only.
- req_i  input  CH_NUM  per-channel request, level-sensitive; bit k = channel k.
- done_i  input  1  one-cycle pulse from the transfer engine; ends the current grant.
- gnt_vld_o  output  1  a grant is active.
- gnt_idx_o  output  IDX_W  binary index of the granted channel; valid only while gnt_vld_o = 1.
- gnt_o  output  CH_NUM  one-hot grant; all zero when gnt_vld_o = 0.
- busy_o  output  1  high in GRANT state (equals gnt_vld_o); kept as a separate port for the status register.

## Operation
- The FSM has two states: IDLE and GRANT. The round-robin pointer ptr has width IDX_W and range 0..CH_NUM-1.
- Reset (rst_i = 1 at a clock edge) forces the following, overriding all other inputs:
  - state = IDLE, ptr = 0
  - gnt_vld_o = 0, gnt_idx_o = 0, gnt_o = 0, busy_o = 0
- IDLE:
  - Condition for a grant: en_i = 1 and req_i != 0.
  - Selected channel = first k with req_i[k] = 1, searching ptr, ptr+1, ..., CH_NUM-1, 0, ..., ptr-1.
  - Selection is registered into gnt_idx_o and gnt_o, and the FSM moves to GRANT.
  - If the condition is not met, the FSM stays in IDLE and outputs stay zero.
- GRANT:
  - Outputs are held constant.
  - Deasserting the granted req_i bit, or driving en_i = 0, does not revoke the grant.
  - On done_i = 1: ptr is set to gnt_idx_o+1, wrapping from CH_NUM-1 to 0.
  - In the same cycle, a new arbitration runs using the updated pointer, current req_i and current en_i.
  - If it succeeds, the new grant is loaded back-to-back and the FSM stays in GRANT.
  - Otherwise the outputs clear and the FSM moves to IDLE.
- done_i in IDLE is ignored.
- ptr changes only on a done_i that ends a grant.
- Channel indices >= CH_NUM never appear; gnt_o bit k is 1 only for k = gnt_idx_o.

## Timing
- Request-to-grant latency: req_i/en_i sampled at edge N (IDLE) produces gnt_vld_o = 1 after edge N.
- Back-to-back handoff: done_i at edge N causes the new grant (or the clear) to be visible after edge N, with zero idle cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A reset asserted during GRANT clears the grant at the next edge; an in-flight done_i in that cycle is discarded.

## Structure
- Package dma_pkg holds:
  - DMA_CH_NUM_DEF = 16
  - DMA_IDX_W_DEF = 4
  - a state enum {ARB_IDLE, ARB_GRANT}
- Sub-module decoder_bin2oh:
  - Parametrised combinational binary-to-one-hot decoder, parameters IDX_W and OUT_W, with enable.
  - It replaces the cascaded fixed-size decoders.
  - It generates the next-state value of gnt_o from the next index, which is then registered.
- The round-robin search is a rotate / priority-encode / un-rotate in the arbiter body. Implementers must handle the non-power-of-two wrap explicitly.

## Test plan
All scenarios use CH_NUM = 16, IDX_W = 4 unless stated.
- Reset with req_i = 16'hFFFF held → all outputs 0; after release with en_i = 1, the next edge gives gnt_idx_o = 0 and gnt_o = 16'h0001.
- Fairness: req_i = 16'h8011 constant, done_i pulsed once per grant → grants follow the order 0, 4, 15, 0, 4 with no idle cycles between them.
- Wrap: a grant on channel 15 ends with req_i = 16'h0006 → next grant is gnt_idx_o = 1, gnt_o = 16'h0002.
- Hold: grant on channel 3; then drop req_i[3], drive en_i = 0 and raise other requests → gnt_idx_o stays 3 until done_i. After done_i with en_i = 0, outputs clear and the FSM enters IDLE.
- Non-power-of-two, CH_NUM = 5, IDX_W = 3: a grant on channel 4 ends with req_i = 5'b00001 → grant on channel 0; gnt_idx_o never reaches 5..7.
- Reset mid-grant: done_i and rst_i asserted together → next edge all outputs 0 and ptr = 0 (verified by the next grant from req_i = 16'hFFFF being channel 0).

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA channel arbiter.
// Imported by the arbiter and its decoder.
package dma_pkg;

  localparam int DMA_CH_NUM_DEF = 16;
  localparam int DMA_IDX_W_DEF  = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder_bin2oh.sv
// Parametrised binary-to-one-hot decoder with enable.
// Indices at or above OUT_W decode to all zeros.
module decoder_bin2oh #(
  parameter int IDX_W = 4,
  parameter int OUT_W = 16
) (
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [OUT_W-1:0] oh_o
);

  // one bit per output position, gated by enable
  always_comb begin
    oh_o = '0;
    for (int k = 0; k < OUT_W; k++) begin
      oh_o[k] = en_i && (idx_i == IDX_W'(k));
    end
  end

endmodule

// File: rtl/dma_chan_arbiter.sv
// Round-robin DMA channel arbiter with held grants.
// Registered binary index plus registered one-hot select.
module dma_chan_arbiter
  import dma_pkg::*;
#(
  parameter int CH_NUM = DMA_CH_NUM_DEF,
  parameter int IDX_W  = DMA_IDX_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [CH_NUM-1:0] req_i,
  input  logic              done_i,
  output logic              gnt_vld_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic [CH_NUM-1:0] gnt_o,
  output logic              busy_o
);

  arb_state_e        state_q, state_n;
  logic [IDX_W-1:0]  ptr_q, ptr_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [CH_NUM-1:0] gnt_q, gnt_n;
  logic              vld_n;

  logic [IDX_W-1:0]  ptr_inc;
  logic [IDX_W-1:0]  sptr;
  logic [IDX_W-1:0]  sel;
  logic [CH_NUM-1:0] rot;
  logic              hit;

  // pointer after the current grant, wrapping at the last real channel
  always_comb begin
    if (idx_q == IDX_W'(CH_NUM - 1)) ptr_inc = '0;
    else                             ptr_inc = idx_q + 1'b1;
  end

  // a finishing grant searches from the advanced pointer
  assign sptr = (state_q == ARB_GRANT) ? ptr_inc : ptr_q;

  // rotate by sptr mod CH_NUM, pick lowest, rotate the index back
  always_comb begin
    int j;
    int off;
    int s;
    rot = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      j = k + int'(sptr);
      if (j >= CH_NUM) j = j - CH_NUM;
      rot[k] = req_i[j];
    end
    hit = |rot;
    off = 0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    s = off + int'(sptr);
    if (s >= CH_NUM) s = s - CH_NUM;
    sel = IDX_W'(s);
  end

  // next state, pointer and grant index
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    idx_n   = idx_q;
    vld_n   = (state_q == ARB_GRANT);
    unique case (state_q)
      ARB_IDLE: begin
        if (en_i && hit) begin
          state_n = ARB_GRANT;
          idx_n   = sel;
          vld_n   = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (done_i) begin
          ptr_n = ptr_inc;
          if (en_i && hit) begin
            idx_n = sel;
          end else begin
            state_n = ARB_IDLE;
            idx_n   = '0;
            vld_n   = 1'b0;
          end
        end
      end
      default: begin
        state_n = ARB_IDLE;
        idx_n   = '0;
        vld_n   = 1'b0;
      end
    endcase
  end

  decoder_bin2oh #(
    .IDX_W(IDX_W),
    .OUT_W(CH_NUM)
  ) u_dec (
    .en_i (vld_n),
    .idx_i(idx_n),
    .oh_o (gnt_n)
  );

  // state and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      idx_q   <= idx_n;
      gnt_q   <= gnt_n;
    end
  end

  assign gnt_vld_o = (state_q == ARB_GRANT);
  assign busy_o    = (state_q == ARB_GRANT);
  assign gnt_idx_o = idx_q;
  assign gnt_o     = gnt_q;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// Bench for dma_chan_arbiter: vector table, 5-channel corner
// case, and random traffic against a round-robin reference.
module tb_dma_chan_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        done = 1'b0;
  logic [15:0] req = '0;
  logic [4:0]  req5 = '0;

  logic        vld, busy;
  logic [3:0]  idx;
  logic [15:0] gnt;
  logic        vld5, busy5;
  logic [2:0]  idx5;
  logic [4:0]  gnt5;

  int errors = 0;
  int checks = 0;

  int g16 = -1, p16 = 0;
  int g5 = -1, p5 = 0;

  always #5 clk = ~clk;

  dma_chan_arbiter #(.CH_NUM(16), .IDX_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
    .done_i(done), .gnt_vld_o(vld), .gnt_idx_o(idx),
    .gnt_o(gnt), .busy_o(busy)
  );

  dma_chan_arbiter #(.CH_NUM(5), .IDX_W(3)) dut5 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req5),
    .done_i(done), .gnt_vld_o(vld5), .gnt_idx_o(idx5),
    .gnt_o(gnt5), .busy_o(busy5)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        done;
    logic [15:0] req;
    logic        vld;
    logic [3:0]  idx;
    logic [15:0] gnt;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // first requesting channel at or after p, walking the ring of n
  function automatic int pick(input int n, input int p,
                              input logic [15:0] r, input logic e);
    if (!e) return -1;
    for (int i = 0; i < n; i++) begin
      if (r[(p + i) % n]) return (p + i) % n;
    end
    return -1;
  endfunction

  task automatic ref_step(input int n, input logic [15:0] r,
                          inout int g, inout int p);
    if (rst) begin
      g = -1;
      p = 0;
    end else if (g < 0) begin
      g = pick(n, p, r, en);
    end else if (done) begin
      p = (g + 1) % n;
      g = pick(n, p, r, en);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    ref_step(16, req, g16, p16);
    ref_step(5, {11'd0, req5}, g5, p5);
    #1;
  endtask

  task automatic chk_models;
    logic [15:0] e16;
    logic [4:0]  e5;
    e16 = (g16 >= 0) ? (16'd1 << g16) : 16'd0;
    e5  = (g5 >= 0) ? (5'd1 << g5) : 5'd0;
    chk("ref16_vld", 64'(vld), 64'(g16 >= 0));
    chk("ref16_busy", 64'(busy), 64'(g16 >= 0));
    chk("ref16_idx", 64'(idx), (g16 >= 0) ? 64'(g16) : 64'd0);
    chk("ref16_gnt", 64'(gnt), 64'(e16));
    chk("ref5_vld", 64'(vld5), 64'(g5 >= 0));
    chk("ref5_busy", 64'(busy5), 64'(g5 >= 0));
    chk("ref5_idx", 64'(idx5), (g5 >= 0) ? 64'(g5) : 64'd0);
    chk("ref5_gnt", 64'(gnt5), 64'(e5));
  endtask

  initial begin
    logic [31:0] rnd;
    // rst en done req | vld idx gnt
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 4'd0,  16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 4'd0,  16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h8011, 1'b1, 4'd0,  16'h0001};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h8011, 1'b1, 4'd4,  16'h0010};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h8011, 1'b1, 4'd15, 16'h8000};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h8011, 1'b1, 4'd0,  16'h0001};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h8011, 1'b1, 4'd4,  16'h0010};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 4'd15, 16'h8000};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 4'd1,  16'h0002};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 4'd0,  16'h0000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0008, 1'b1, 4'd3,  16'h0008};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'hFFF7, 1'b1, 4'd3,  16'h0008};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd3,  16'h0008};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 4'd0,  16'h0000};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 4'd0,  16'h0000};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 4'd4,  16'h0010};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 4'd0,  16'h0000};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 4'd0,  16'h0001};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 4'd0,  16'h0000};

    for (int i = 0; i < 19; i++) begin
      rst  = tbl[i].rst;
      en   = tbl[i].en;
      done = tbl[i].done;
      req  = tbl[i].req;
      req5 = '0;
      tick();
      chk($sformatf("vec%0d_vld", i), 64'(vld), 64'(tbl[i].vld));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].vld));
      chk($sformatf("vec%0d_idx", i), 64'(idx), 64'(tbl[i].idx));
      chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
    end

    // five channels: wrap from channel 4 back to channel 0
    rst = 1'b1; en = 1'b1; done = 1'b0; req = '0; req5 = '0;
    tick();
    chk("ch5_rst_vld", 64'(vld5), 64'd0);
    rst = 1'b0; req5 = 5'b10000;
    tick();
    chk("ch5_first_idx", 64'(idx5), 64'd4);
    chk("ch5_first_gnt", 64'(gnt5), 64'h10);
    done = 1'b1; req5 = 5'b00001;
    tick();
    chk("ch5_wrap_idx", 64'(idx5), 64'd0);
    chk("ch5_wrap_gnt", 64'(gnt5), 64'h01);
    chk("ch5_wrap_vld", 64'(vld5), 64'd1);
    req5 = 5'b00000;
    tick();
    chk("ch5_clear_vld", 64'(vld5), 64'd0);
    chk("ch5_clear_gnt", 64'(gnt5), 64'h00);
    done = 1'b0;

    // random traffic against the reference ring model
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 63) == 0);
      en   = ($urandom_range(0, 7) != 0);
      done = ($urandom_range(0, 2) == 0);
      rnd  = $urandom;
      if ($urandom_range(0, 1) == 1) rnd = rnd & $urandom & $urandom;
      req  = rnd[15:0];
      req5 = rnd[20:16];
      tick();
      chk_models();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
